// File: rtl/sized_data_memory.sv
// Byte-addressed little-endian data memory with byte/half/word access and a
// req/ready/valid handshake of WAIT_CYCLES+1 latency. Optional: DMEM_MISALIGN_TRAP_EN.
module sized_data_memory #(
    parameter int DEPTH_BYTES = 128,
    parameter int WAIT_CYCLES = 0
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        req_i,
    input  logic        we_i,
    input  logic [1:0]  size_i,
    input  logic        unsigned_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] data_i,
    output logic        ready_o,
    output logic        valid_o,
    output logic [31:0] data_o,
    output logic        err_o
);
    localparam int AW = $clog2(DEPTH_BYTES);

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t         state;
    logic [3:0]     cnt;
    logic           we_q, uns_q;
    logic [1:0]     size_q;
    logic [AW-1:0]  addr_q;
    logic [31:0]    wdata_q;

    logic [7:0]     mem [DEPTH_BYTES] = '{default: 8'h00};

    logic           accept, commit, trap;
    logic           op_we, op_uns;
    logic [1:0]     op_size;
    logic [AW-1:0]  op_addr, base;
    logic [31:0]    op_wdata, ld_val, resp_data;
    logic [AW-1:0]  a [4];
    logic [7:0]     r [4];
    logic [3:0]     be;
    logic           unused_bits;

    assign unused_bits = ^addr_i[31:AW];

    // With no wait states the access executes on the accepting edge, so the
    // operation is taken straight from the ports while IDLE.
    assign accept = (state == IDLE) && req_i;
    assign commit = rst_i && (((WAIT_CYCLES == 0) && accept) ||
                              ((state == WAIT) && (cnt == 4'd0)));

    assign op_we    = (state == IDLE) ? we_i              : we_q;
    assign op_uns   = (state == IDLE) ? unsigned_i        : uns_q;
    assign op_size  = (state == IDLE) ? size_i            : size_q;
    assign op_addr  = (state == IDLE) ? addr_i[AW-1:0]    : addr_q;
    assign op_wdata = (state == IDLE) ? data_i            : wdata_q;

`ifdef DMEM_MISALIGN_TRAP_EN
    assign base = op_addr;
    assign trap = ((op_size == 2'b01) && op_addr[0]) || (op_size[1] && (op_addr[1:0] != 2'b00));
`else
    always_comb begin
        base = op_addr;
        if (op_size == 2'b01) base[0] = 1'b0;
        else if (op_size[1])  base[1:0] = 2'b00;
    end
    assign trap = 1'b0;
`endif

    // Byte lanes wrap modulo the array size through AW-bit addition.
    always_comb begin
        for (int k = 0; k < 4; k++) begin
            a[k] = base + AW'(k);
            r[k] = mem[a[k]];
        end
    end

    assign be = {op_size[1], op_size[1], (op_size != 2'b00), 1'b1};

    always_comb begin
        case (op_size)
            2'b00:   ld_val = {{24{~op_uns & r[0][7]}}, r[0]};
            2'b01:   ld_val = {{16{~op_uns & r[1][7]}}, r[1], r[0]};
            default: ld_val = {r[3], r[2], r[1], r[0]};
        endcase
    end

    assign resp_data = (op_we || trap) ? 32'd0 : ld_val;

    // Storage is deliberately outside reset: committed stores survive it.
    always_ff @(posedge clk_i) begin
        if (commit && op_we && !trap) begin
            for (int k = 0; k < 4; k++)
                if (be[k]) mem[a[k]] <= op_wdata[8*k +: 8];
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state   <= IDLE;
            cnt     <= 4'd0;
            we_q    <= 1'b0;
            uns_q   <= 1'b0;
            size_q  <= 2'b00;
            addr_q  <= '0;
            wdata_q <= 32'd0;
            ready_o <= 1'b1;
            valid_o <= 1'b0;
            data_o  <= 32'd0;
            err_o   <= 1'b0;
        end else begin
            case (state)
                IDLE: if (accept) begin
                    we_q    <= we_i;
                    uns_q   <= unsigned_i;
                    size_q  <= size_i;
                    addr_q  <= addr_i[AW-1:0];
                    wdata_q <= data_i;
                    ready_o <= 1'b0;
                    if (WAIT_CYCLES == 0) begin
                        state   <= RESP;
                        valid_o <= 1'b1;
                        data_o  <= resp_data;
                        err_o   <= trap;
                    end else begin
                        state <= WAIT;
                        cnt   <= 4'(WAIT_CYCLES - 1);
                    end
                end
                WAIT: begin
                    if (cnt == 4'd0) begin
                        state   <= RESP;
                        valid_o <= 1'b1;
                        data_o  <= resp_data;
                        err_o   <= trap;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                RESP: begin
                    state   <= IDLE;
                    valid_o <= 1'b0;
                    ready_o <= 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: doc/sized_data_memory.md
# sized_data_memory

Parametrised, byte-addressed, little-endian data memory with byte/halfword/word access, load sign/zero extension and a request/response handshake with configurable access latency. It replaces the single-cycle word-only data memory in the pipelined CPU's MEM stage. The memory can model slow storage, so the pipeline stalls on `ready_o` and `valid_o` instead of relying on a fixed combinational read.

## Interface
Parameters:
- `DEPTH_BYTES`, default 128: storage size in bytes. Must be a power of two, at least 4.
- `WAIT_CYCLES`, default 0: extra wait cycles inserted between request acceptance and response. Allowed range is 0–15.

Ports:
- `clk_i`, in, 1: clock. All state changes on the rising edge.
- `rst_i`, in, 1: reset. Asynchronous, active-low.
- `req_i`, in, 1: request strobe.
- `we_i`, in, 1: 1 = store, 0 = load.
- `size_i`, in, 2: access size. 00 = byte, 01 = halfword, 10 = word, 11 = reserved (treated as word).
- `unsigned_i`, in, 1: loads only. 1 = zero-extend, 0 = sign-extend.
- `addr_i`, in, 32: byte address.
- `data_i`, in, 32: store data. Byte stores use [7:0]; halfword stores use [15:0].
- `ready_o`, out, 1: block can accept a request.
- `valid_o`, out, 1: response valid. High for exactly one cycle per request.
- `data_o`, out, 32: load result. 0 for stores.
- `err_o`, out, 1: misaligned-access flag. Qualified by `valid_o`.

## Operation
- The storage array holds `DEPTH_BYTES` bytes and is zero-initialised at time 0.
  - Reset does not clear the storage array.
- Effective address is `addr_i` modulo `DEPTH_BYTES`, using the low log2(`DEPTH_BYTES`) bits.
  - A multi-byte access that runs past the top wraps to byte 0.
- Byte order is little-endian: the lowest address holds bits [7:0].
- States: IDLE, WAIT, RESP.
  - IDLE: `ready_o`=1. If `req_i` is 1, the block latches `we_i`, `size_i`, `unsigned_i`, `addr_i` and `data_i`.
    - Goes to WAIT if `WAIT_CYCLES`>0, otherwise to RESP.
  - WAIT: a down-counter is loaded with `WAIT_CYCLES`−1 on entry and decrements each cycle. The block goes to RESP on the edge where the counter equals 0.
  - RESP: `valid_o`=1 for one cycle, then unconditional return to IDLE.
- The memory operation executes on the edge that enters RESP, using the latched request:
  - Store: writes 1, 2 or 4 bytes. Other bytes are unchanged.
  - Load: `data_o` receives the extended value. `data_o` holds that value until the next response.
- `req_i` is ignored outside IDLE. No queueing.
- `data_o` for a store response is 0.

## Timing
- Reset values: state IDLE, `ready_o`=1, `valid_o`=0, `data_o`=0, `err_o`=0, counter 0.
- Request accepted at edge N (IDLE and `req_i`=1) → `valid_o` is high in the cycle after edge N+`WAIT_CYCLES`.
  - Example: with `WAIT_CYCLES`=0, the response appears in the cycle right after acceptance.
- `ready_o` is low from edge N until the edge that ends RESP.
  - Maximum throughput is one request per `WAIT_CYCLES`+2 cycles.
- A store is visible to a load accepted in the cycle after its RESP (back-to-back read-after-write returns the new data).
- Reset asserted mid-operation:
  - The block goes to IDLE immediately.
  - A store not yet committed (still in WAIT) is discarded.
  - A store already committed is retained.
  - `valid_o` drops asynchronously.
- Input changes after acceptance have no effect on the in-flight request.

## Configuration
- `DMEM_MISALIGN_TRAP_EN` defined:
  - Misaligned accesses are halfword with addr[0]=1, or word/reserved with addr[1:0]≠0.
  - A misaligned access performs no write and returns `data_o`=0.
  - It responds with `err_o`=1 alongside `valid_o` (same latency).
  - Aligned accesses give `err_o`=0.
- `DMEM_MISALIGN_TRAP_EN` undefined:
  - Low address bits are forced to alignment: bit 0 is cleared for halfword, bits [1:0] are cleared for word.
  - The access proceeds at the aligned address.
  - `err_o` is constant 0.

## Test plan
- Reset → `ready_o`=1, `valid_o`=0, `data_o`=0, `err_o`=0. Word load at 0x0 → 0x00000000.
- `WAIT_CYCLES`=0: word store 0xDEADBEEF at 0x8, then:
  - byte load at 0x9 with `unsigned_i`=0 → 0xFFFFFFBE;
  - byte load at 0x9 with `unsigned_i`=1 → 0x000000BE;
  - halfword load at 0xA with `unsigned_i`=0 → 0xFFFFDEAD.
- Byte store 0x12 at 0xB over the above, then word load at 0x8 → 0x12ADBEEF.
- `WAIT_CYCLES`=3: request at edge N → `valid_o` high only in the cycle after edge N+3. `ready_o` is low in between, and `req_i` pulses in that window are ignored.
- Word store 0x11223344 at `DEPTH_BYTES`−2 (0x7E) with the macro undefined → written at 0x7C; word load at 0x7C → 0x11223344.
  - Same request with the macro defined → `err_o`=1 and memory unchanged.
- Reset pulse during WAIT of a store to 0x10 → word load at 0x10 afterwards returns 0x00000000.
